// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the push-button conditioner: default debounce time,
// counter width and the button index order used for packed button vectors.
package btn_conditioner_pkg;

  // 10 ms at a 65 MHz pixel clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 650000;
  localparam int unsigned CNT_W               = 20;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 3;

endpackage : btn_conditioner_pkg

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, qualification counter, stable
// level register and a registered single-cycle press pulse on 0->1 acceptance.
module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o,
  output logic lvl_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Any cycle where sync2 agrees with stable clears the count, so a bounce
  // back to the old level restarts qualification from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q >= CNT_LAST) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign lvl_o   = stable_q;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// Four independent debounce channels for the board push-buttons, plus an
// any-press strobe for the game FSM.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic btnR_raw,
  input  logic btnU_raw,
  input  logic btnD_raw,
  input  logic btnL_raw,
  output logic btnR,
  output logic btnU,
  output logic btnD,
  output logic btnL,
  output logic btnR_lvl,
  output logic btnU_lvl,
  output logic btnD_lvl,
  output logic btnL_lvl,
  output logic any_btn
);

  logic [3:0] press;
  logic [3:0] lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk_i(pclk), .rst_ni(rst_n), .raw_i(btnR_raw),
    .pulse_o(press[BTN_R]), .lvl_o(lvl[BTN_R])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
    .clk_i(pclk), .rst_ni(rst_n), .raw_i(btnU_raw),
    .pulse_o(press[BTN_U]), .lvl_o(lvl[BTN_U])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_d (
    .clk_i(pclk), .rst_ni(rst_n), .raw_i(btnD_raw),
    .pulse_o(press[BTN_D]), .lvl_o(lvl[BTN_D])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
    .clk_i(pclk), .rst_ni(rst_n), .raw_i(btnL_raw),
    .pulse_o(press[BTN_L]), .lvl_o(lvl[BTN_L])
  );

  assign btnR     = press[BTN_R];
  assign btnU     = press[BTN_U];
  assign btnD     = press[BTN_D];
  assign btnL     = press[BTN_L];
  assign btnR_lvl = lvl[BTN_R];
  assign btnU_lvl = lvl[BTN_U];
  assign btnD_lvl = lvl[BTN_D];
  assign btnL_lvl = lvl[BTN_L];
  assign any_btn  = |press;

endmodule : btn_conditioner
